// File: rtl/alu_mul_ctrl.sv
// Sequencer for 16x16 shift-add multiply on a shared 16-bit ALU.
// Ports: start/signed_op/op_a/op_b in; ready/done/product out; alu_* ALU link.
module alu_mul_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        ready,
  output logic        done,
  output logic [31:0] product,
  output logic [15:0] alu_InA,
  output logic [15:0] alu_InB,
  output logic [3:0]  alu_Oper,
  output logic        alu_Cin,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic        alu_sign,
  input  logic [15:0] alu_Out,
  input  logic        alu_CF
);

  typedef enum logic [2:0] {
    IDLE, NEGA, NEGB, MUL, NEGLO, NEGHI, DONE
  } state_t;

  state_t      state;
  logic [15:0] mcand;
  logic [15:0] acc_hi;
  logic [15:0] mplier_lo;
  logic [3:0]  cnt;
  logic        sgn;
  logic        neg;
  logic        borrow;
  logic [31:0] sh;

  // ALU sum plus carry, shifted right one place into {acc_hi, mplier_lo}
  assign sh = {alu_CF, alu_Out, mplier_lo[15:1]};

  assign alu_Oper = 4'b0000;
  assign alu_sign = 1'b0;
  assign alu_invB = 1'b0;

  always_comb begin
    alu_InA  = '0;
    alu_InB  = '0;
    alu_Cin  = 1'b0;
    alu_invA = 1'b0;
    unique case (state)
      NEGA: begin
        alu_InA  = mcand;
        alu_invA = mcand[15];
        alu_Cin  = mcand[15];
      end
      NEGB: begin
        alu_InA  = mplier_lo;
        alu_invA = mplier_lo[15];
        alu_Cin  = mplier_lo[15];
      end
      MUL: begin
        alu_InA = acc_hi;
        alu_InB = mplier_lo[0] ? mcand : '0;
      end
      NEGLO: begin
        alu_InA  = mplier_lo;
        alu_invA = neg;
        alu_Cin  = neg;
      end
      NEGHI: begin
        alu_InA  = acc_hi;
        alu_invA = neg;
        alu_Cin  = borrow;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      product   <= '0;
      mcand     <= '0;
      acc_hi    <= '0;
      mplier_lo <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      neg       <= 1'b0;
      borrow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand     <= op_a;
            mplier_lo <= op_b;
            acc_hi    <= '0;
            cnt       <= '0;
            sgn       <= signed_op;
            neg       <= signed_op & (op_a[15] ^ op_b[15]);
            borrow    <= 1'b0;
            ready     <= 1'b0;
            state     <= signed_op ? NEGA : MUL;
          end
        end
        NEGA: begin
          mcand <= alu_Out;
          state <= NEGB;
        end
        NEGB: begin
          mplier_lo <= alu_Out;
          acc_hi    <= '0;
          state     <= MUL;
        end
        MUL: begin
          {acc_hi, mplier_lo} <= sh;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            if (sgn) begin
              state <= NEGLO;
            end else begin
              product <= sh;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        NEGLO: begin
          // carry out of the low half only occurs when negating zero
          mplier_lo <= alu_Out;
          borrow    <= alu_CF & neg;
          state     <= NEGHI;
        end
        NEGHI: begin
          acc_hi  <= alu_Out;
          product <= {alu_Out, mplier_lo};
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Randomized self-checking bench for alu_mul_ctrl.
// Models the shared ALU and checks products against plain arithmetic.
module tb_alu_mul_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        ready;
  logic        done;
  logic [31:0] product;
  logic [15:0] alu_InA;
  logic [15:0] alu_InB;
  logic [3:0]  alu_Oper;
  logic        alu_Cin;
  logic        alu_invA;
  logic        alu_invB;
  logic        alu_sign;
  logic [15:0] alu_Out;
  logic        alu_CF;

  int errs = 0;
  int checks = 0;

  alu_mul_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .signed_op(signed_op),
    .op_a(op_a),
    .op_b(op_b),
    .ready(ready),
    .done(done),
    .product(product),
    .alu_InA(alu_InA),
    .alu_InB(alu_InB),
    .alu_Oper(alu_Oper),
    .alu_Cin(alu_Cin),
    .alu_invA(alu_invA),
    .alu_invB(alu_invB),
    .alu_sign(alu_sign),
    .alu_Out(alu_Out),
    .alu_CF(alu_CF)
  );

  // 16-bit adder ALU with optional operand inversion
  logic [16:0] alu_sum;
  assign alu_sum = {1'b0, alu_invA ? ~alu_InA : alu_InA}
                 + {1'b0, alu_invB ? ~alu_InB : alu_InB}
                 + {16'd0, alu_Cin};
  assign alu_Out = alu_sum[15:0];
  assign alu_CF  = alu_sum[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input bit s,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    int sa;
    int sb;
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      return 32'(sa * sb);
    end
    return {16'd0, a} * {16'd0, b};
  endfunction

  task automatic run_op(input bit s,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input bit hold);
    logic [31:0] exp;
    int lat;
    int seen;
    exp = ref_mul(s, a, b);
    lat = s ? 21 : 17;
    @(negedge clk);
    chk("ready_idle", 32'(ready), 32'd1);
    start = 1'b1;
    signed_op = s;
    op_a = a;
    op_b = b;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      op_a = ~a;
      op_b = b + 16'd1;
      signed_op = ~s;
    end else begin
      start = 1'b0;
    end
    seen = -1;
    for (int k = 0; k < lat + 5 && seen < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) chk("busy_ready", 32'(ready), 32'd0);
      if (done) seen = k;
    end
    start = 1'b0;
    chk("latency", 32'(seen + 1), 32'(lat));
    chk("product", product, exp);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("ready_back", 32'(ready), 32'd1);
    chk("product_hold", product, exp);
  endtask

  task automatic reset_mid_mul();
    int ndone;
    @(negedge clk);
    start = 1'b1;
    signed_op = 1'b0;
    op_a = 16'h1234;
    op_b = 16'h5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_alu_ina", 32'(alu_InA), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_rst", 32'(ndone), 32'd0);
    chk("idle_after_rst", 32'(ready), 32'd1);
  endtask

  logic [15:0] edges [5];
  logic [15:0] ra;
  logic [15:0] rb;
  bit          rs;

  initial begin
    edges[0] = 16'h0000;
    edges[1] = 16'h0001;
    edges[2] = 16'h7FFF;
    edges[3] = 16'h8000;
    edges[4] = 16'hFFFF;
    rst_n = 1'b0;
    start = 1'b0;
    signed_op = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", product, 32'd0);
    chk("reset_alu", {alu_InA, alu_InB}, 32'd0);
    rst_n = 1'b1;

    run_op(1'b0, 16'd3, 16'd5, 1'b0);
    chk("u3x5", product, 32'h0000000F);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("uffff", product, 32'hFFFE0001);
    run_op(1'b1, 16'hFFFD, 16'd7, 1'b0);
    chk("s_m3x7", product, 32'hFFFFFFEB);
    run_op(1'b1, 16'h8000, 16'h8000, 1'b0);
    chk("s8000", product, 32'h40000000);
    run_op(1'b0, 16'd3, 16'd5, 1'b1);
    run_op(1'b1, 16'h0000, 16'hFFFF, 1'b0);
    chk("s0xm1", product, 32'h00000000);
    run_op(1'b0, 16'h8000, 16'h8000, 1'b0);
    reset_mid_mul();

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = ($urandom % 4 == 0) ? edges[$urandom % 5] : 16'($urandom);
      rb = ($urandom % 4 == 0) ? edges[$urandom % 5] : 16'($urandom);
      run_op(rs, ra, rb, 1'($urandom % 5 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
